// File: rtl/pc_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg_if
// Description : Bundle between next-PC select logic (master) and the
//               program-counter register (slave). The instret trace signal
//               exists only when PC_TRACE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_reg_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pcPlus4;
  logic             misaligned;
`ifdef PC_TRACE_EN
  logic [63:0]      instret;
`endif

  // Next-PC logic: drives the load request, observes the current PC.
  modport master (
    output en,
    output pcNext,
`ifdef PC_TRACE_EN
    input  instret,
`endif
    input  pc,
    input  pcPlus4,
    input  misaligned
  );

  // PC register: accepts the load request, publishes the current PC.
  modport slave (
    input  en,
    input  pcNext,
`ifdef PC_TRACE_EN
    output instret,
`endif
    output pc,
    output pcPlus4,
    output misaligned
  );
endinterface
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program-counter register of the single-cycle RISC-V core.
//               Loads pcNext on a rising clk edge when en is high, holds it
//               otherwise. Supplies pc + 4 and a misalignment flag.
//               Optional macro PC_TRACE_EN adds a 64-bit instret counter of
//               load cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
  input  wire logic clk,
  input  wire logic rst_n,
  pc_reg_if.slave   bus
);

  logic [WIDTH-1:0] r_pc;

  // PC state: async reset to the vector, load pcNext unmasked when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_VECTOR;
    end else if (bus.en) begin
      r_pc <= bus.pcNext;
    end
  end

  assign bus.pc         = r_pc;
  // Wraps modulo 2^WIDTH naturally through the fixed-width add.
  assign bus.pcPlus4    = r_pc + WIDTH'(4);
  // Flag only; the register never masks the low bits.
  assign bus.misaligned = |r_pc[1:0];

`ifdef PC_TRACE_EN
  logic [63:0] r_instret;

  // Retired-load counter: counts every enabled edge, wraps at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= 64'd0;
    end else if (bus.en) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign bus.instret = r_instret;
`else
  // Trace counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_reg
// Description : Directed self-checking bench for pc_reg. Outputs are sampled
//               on falling clk edges or between edges, away from the active
//               rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_reg;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pc_reg_if #(.WIDTH(32)) bus ();

  pc_reg #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks = n_checks + 1;
    if (observed !== expected) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.pcNext = 32'h1234_5678;

    // Reset held with clk running: pc stays at the vector.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pc", bus.pc, 32'h0000_0000);
      check("rst_pc4", bus.pcPlus4, 32'h0000_0004);
      check("rst_mis", bus.misaligned, 1'b0);
    end

    // Release reset between edges; first load happens only at the next edge.
    bus.pcNext = 32'hFFFF_FFFF;
    rst_n      = 1'b1;
    #1;
    check("rel_hold", bus.pc, 32'h0000_0000);
    @(negedge clk);
    check("ld_ff_pc", bus.pc, 32'hFFFF_FFFF);
    check("ld_ff_mis", bus.misaligned, 1'b1);
    check("ld_ff_pc4", bus.pcPlus4, 32'h0000_0003);

    // Aligned value clears the flag after one edge.
    bus.pcNext = 32'h0000_0000;
    @(negedge clk);
    check("ld_0_pc", bus.pc, 32'h0000_0000);
    check("ld_0_mis", bus.misaligned, 1'b0);
    check("ld_0_pc4", bus.pcPlus4, 32'h0000_0004);

    // pcNext changing mid-cycle must not reach pc before the rising edge.
    bus.pcNext = 32'h0000_0040;
    #2;
    check("mid_hold", bus.pc, 32'h0000_0000);
    @(negedge clk);
    check("mid_load", bus.pc, 32'h0000_0040);

    // Stall for three edges, then resume.
    bus.en     = 1'b0;
    bus.pcNext = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc", bus.pc, 32'h0000_0040);
    end
    bus.en = 1'b1;
    @(negedge clk);
    check("resume_pc", bus.pc, 32'h0000_0100);
    check("resume_pc4", bus.pcPlus4, 32'h0000_0104);

    // Async reset between edges takes effect immediately.
    bus.pcNext = 32'h0000_0200;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_pc", bus.pc, 32'h0000_0000);
    check("async_pc4", bus.pcPlus4, 32'h0000_0004);
    #1;
    rst_n = 1'b1;
    #1;
    check("async_rel", bus.pc, 32'h0000_0000);
    @(negedge clk);
    check("post_rst", bus.pc, 32'h0000_0200);

    // pcPlus4 wraps at the top of the address space.
    bus.pcNext = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.pcPlus4, 32'h0000_0000);
    check("wrap_mis", bus.misaligned, 1'b0);

    // Misaligned by one bit only.
    bus.pcNext = 32'h0000_0102;
    @(negedge clk);
    check("mis2_flag", bus.misaligned, 1'b1);
    check("mis2_pc4", bus.pcPlus4, 32'h0000_0106);

`ifdef PC_TRACE_EN
    // instret: 5 enabled edges, 2 stalled edges, then reset.
    rst_n = 1'b0;
    #1;
    check("ir_rst", bus.instret, 64'd0);
    bus.en = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 2; i++) @(negedge clk);
    check("ir_count", bus.instret, 64'd5);
    rst_n = 1'b0;
    #1;
    check("ir_clear", bus.instret, 64'd0);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
